// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths and the pending-entry type for the write-port arbiter.
package wb_arb_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: WriteBack, LU result and register-file write-port signals.
interface wb_port_arbiter_if import wb_arb_pkg::*; #(parameter int DEPTH = 2);
    logic                     RegWriteW;
    logic [REGW-1:0]          RdW;
    logic [XLEN-1:0]          ResultW;
    logic                     lu_valid;
    logic [REGW-1:0]          lu_rd;
    logic [XLEN-1:0]          lu_data;
    logic                     lu_ready;
    logic                     rf_we;
    logic [REGW-1:0]          rf_waddr;
    logic [XLEN-1:0]          rf_wdata;
    logic                     wb_stall;
    logic [$clog2(DEPTH):0]   pend_count;

    modport slave (
        input  RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data,
        output lu_ready, rf_we, rf_waddr, rf_wdata, wb_stall, pend_count
    );
    modport master (
        output RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, wb_stall, pend_count
    );
endinterface

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo: small in-order FIFO holding LU results awaiting the write port.
module wb_pend_fifo import wb_arb_pkg::*; #(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign head  = mem[rp];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WriteBack and
// buffered long-latency results, with a bounded-wait forced drain.
module wb_port_arbiter import wb_arb_pkg::*; #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int AGW = $clog2(MAX_WAIT + 1);

    wb_entry_t din, head;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, wb_req, head_v, stall, push, pop;
    logic [AGW-1:0] age;

    assign din    = '{rd: bus.lu_rd, data: bus.lu_data};
    assign wb_req = bus.RegWriteW && bus.RdW != '0;
    assign head_v = !empty;
    assign stall  = head_v && (full || age >= AGW'(MAX_WAIT));
    assign pop    = head_v && (stall || !wb_req);
    // x0 results complete the handshake but are dropped.
    assign push   = bus.lu_valid && bus.lu_ready && bus.lu_rd != '0;

    wb_pend_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age <= '0;
        else age <= (pop || !head_v) ? '0 : (age < AGW'(MAX_WAIT) ? age + 1'b1 : age);
    end

    assign bus.lu_ready   = rst && !full;
    assign bus.wb_stall   = stall;
    assign bus.pend_count = count;
    assign bus.rf_we      = rst && (pop || wb_req);
    assign bus.rf_waddr   = !bus.rf_we ? '0 : pop ? head.rd : bus.RdW;
    assign bus.rf_wdata   = !bus.rf_we ? '0 : pop ? head.data : bus.ResultW;
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order WriteBack stage and a long-latency unit (LU, e.g. multicycle mul/div) that returns results out of pipeline order. LU results are buffered in a small pending FIFO and drain on cycles when WriteBack does not write. A bounded-wait rule stalls the pipeline to force a drain when the FIFO is full or its head has waited too long. The block sits between the WriteBack stage outputs, the LU result interface and the register file. It also drives the hazard unit's stall input.

Parameters:
XLEN, 32, data width
REGW, 5, register index width
DEPTH, 2, pending FIFO entries (power of two, >=2)
MAX_WAIT, 4, cycles the FIFO head may be denied before a forced stall

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
RegWriteW  in  1  WriteBack write enable
RdW  in  REGW  WriteBack destination register
ResultW  in  XLEN  WriteBack result
lu_valid  in  1  LU result valid
lu_rd  in  REGW  LU destination register
lu_data  in  XLEN  LU result
lu_ready  out  1  FIFO can accept; handshake is lu_valid && lu_ready
rf_we  out  1  register-file write enable
rf_waddr  out  REGW  register-file write address
rf_wdata  out  XLEN  register-file write data
wb_stall  out  1  freeze WriteBack and earlier stages this cycle
pend_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (rst low, async): FIFO empty, pointers 0, age 0.
  - While rst is low: rf_we=0, wb_stall=0, lu_ready=0, pend_count=0, rf_waddr/rf_wdata=0.
  - First cycle after release: lu_ready=1.
  - Reset mid-operation discards all pending entries.
- Definitions:
  - wb_req = RegWriteW && RdW!=0. WriteBack writes to x0 never use the port.
  - head_v = pend_count!=0.
- wb_stall = head_v && (pend_count==DEPTH || age>=MAX_WAIT).
  - Driven from registered state only; there is no combinational path from any input to wb_stall.
- Grant logic, combinational, one winner per cycle:
  - If wb_stall: the FIFO head writes. The WriteBack write is suppressed; the pipeline holds it and re-presents it next cycle.
  - Else if wb_req: WriteBack writes (rf_waddr=RdW, rf_wdata=ResultW).
  - Else if head_v: the FIFO head writes and is popped at the clock edge.
  - Else: rf_we=0, and rf_waddr/rf_wdata=0.
- WriteBack path latency: 0 cycles, pass-through.
- LU path latency: a result is enqueued at the handshake edge. It can write the register file at the earliest in the next cycle (minimum 1 cycle).
- lu_ready = pend_count<DEPTH, registered-state based.
  - Push and pop in the same cycle are allowed; pend_count is unchanged.
  - At full, no push occurs because lu_ready=0, and a pop is guaranteed because wb_stall=1.
- LU results with lu_rd==0 are accepted (handshake completes) but not stored; pend_count is unchanged.
- Age counter:
  - Increments each cycle head_v && !head_granted.
  - Clears to 0 when the head is popped or the FIFO is empty.
  - Saturates at MAX_WAIT.
- Worst case: a head waits MAX_WAIT cycles plus 1 before writing.
- FIFO order is strict; entries drain in arrival order. Pointers wrap modulo DEPTH.
- WAW ordering precondition: upstream never issues an instruction writing a register that has an outstanding LU result. The arbiter does not check this. Verification carries an assertion that wb_req's RdW never matches any valid FIFO entry's rd.
- At most one rf_we per cycle. rf_we=1 implies rf_waddr!=0.

Decomposition:
- Shared package wb_arb_pkg:
  - XLEN and REGW constants.
  - Typedef wb_entry_t, a packed struct of rd[REGW] and data[XLEN].
- Sub-module wb_pend_fifo:
  - Parameterised on DEPTH and wb_entry_t.
  - Ports: push, pop, head, count, full, empty; same clk/rst.
- wb_port_arbiter holds the grant mux, age counter and stall logic.

Test Plan:
- Reset held, then released: all outputs 0 during reset. lu_ready=1 and pend_count=0 on the first cycle after release.
- LU push (rd=7, data=0xDEAD_BEEF) with RegWriteW=0: next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; pend_count returns to 0.
- Continuous WriteBack writes (RdW=3) and one LU push (rd=9):
  - WriteBack is granted for MAX_WAIT=4 cycles while age counts 1..4.
  - Then wb_stall=1 for one cycle, in which rd=9 is written and the WriteBack write to x3 is suppressed.
  - wb_stall=0 the following cycle.
- Two back-to-back LU pushes during WriteBack writes: pend_count=2, lu_ready=0, wb_stall=1. Entries drain in push order over the next two stall cycles.
- LU push with lu_rd=0, then WriteBack with RegWriteW=1, RdW=0: handshake completes, pend_count stays 0, rf_we never asserts.
- rst asserted asynchronously while pend_count=2: outputs go to 0 immediately, no register-file write occurs, and pend_count=0 after release.
